// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
//
// Pending-writeback queue sitting in front of a register file. Results from a
// producer are buffered in a circular FIFO and retired one per cycle, strictly
// in acceptance order, whenever drain_en permits. While results are pending, a
// combinational bypass network lets two register-file read ports see the
// youngest pending value for their address.
//
// Writes to x0 (in_rd == 0) are handshaken but never stored.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (clears pointers and count)
//   in_valid   producer offers {in_rd, in_wd} this cycle
//   in_ready   queue has a free entry (count < DEPTH)
//   in_rd      destination register index of the offered result
//   in_wd      offered result data
//   drain_en   allows the head entry to be written this cycle
//   wen        register file write enable (count != 0 && drain_en)
//   rd, wd     register file write address / data (head entry, 0 when empty)
//   rs1, rs2   register file read addresses used for the bypass lookup
//   fwdN_hit   a pending entry targets rsN (never for rsN == 0)
//   fwdN_data  data of the youngest pending entry targeting rsN, else 0
//   count      number of pending entries
// -----------------------------------------------------------------------------
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [63:0]              in_wd,
    input  logic                     drain_en,
    output logic                     wen,
    output logic [4:0]               rd,
    output logic [63:0]              wd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     fwd1_hit,
    output logic [63:0]              fwd1_data,
    output logic                     fwd2_hit,
    output logic [63:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage, split by field.
    logic [4:0]       ent_rd [DEPTH];
    logic [63:0]      ent_wd [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt_q;

    logic             not_empty;
    logic             enq;
    logic             deq;

    assign not_empty = (cnt_q != '0);
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign count     = cnt_q;

    // A handshake with in_rd == 0 completes but is dropped here.
    assign enq = in_valid && in_ready && (in_rd != 5'd0);
    assign deq = wen;

    // Retire port: head entry, forced to zero when nothing is pending.
    assign wen = not_empty && drain_en;
    assign rd  = not_empty ? ent_rd[head] : 5'd0;
    assign wd  = not_empty ? ent_wd[head] : 64'd0;

    // Pointer and occupancy state. Reset wins over any same-edge enqueue or
    // dequeue, and pending entries are simply forgotten.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: the entry array has no reset; cnt_q/head decide which slots are
    // live, so stale contents are never observable and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_rd[tail] <= in_rd;
            ent_wd[tail] <= in_wd;
        end
    end

    // Bypass lookup over live entries only. Walking from the head (oldest)
    // towards the tail (youngest) and letting later matches overwrite earlier
    // ones makes the youngest matching entry win. The incoming in_* result is
    // deliberately not considered.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 64'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 64'd0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = head + PTR_W'(k);
            if (CNT_W'(k) < cnt_q) begin
                if ((rs1 != 5'd0) && (ent_rd[idx] == rs1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = ent_wd[idx];
                end
                if ((rs2 != 5'd0) && (ent_rd[idx] == rs2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = ent_wd[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue
//
// Directed scenarios followed by a randomized run for wb_queue (DEPTH = 4).
// Expected outputs come from a queue-based reference model: a list of pending
// {rd, wd} records, oldest first, updated on every clock edge from the rules of
// the queue (accept when fewer than DEPTH pending, drop x0, retire the oldest
// when drain_en is high and something is pending, reset empties the list).
// Inputs change 1 time unit after the rising edge; outputs are compared at the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [63:0] in_wd;
    logic        drain_en;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic [63:0] fwd1_data;
    logic        fwd2_hit;
    logic [63:0] fwd2_data;
    logic [$clog2(DEPTH):0] count;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_wd     (in_wd),
        .drain_en  (drain_en),
        .wen       (wen),
        .rd        (rd),
        .wd        (wd),
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest pending record targeting rs, searched from the back of the list.
    function automatic void model_fwd(input logic [4:0] rs, output logic hit,
                                      output logic [63:0] data);
        hit  = 1'b0;
        data = 64'd0;
        if (rs != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == rs) begin
                    hit  = 1'b1;
                    data = q[i].wd;
                    break;
                end
            end
        end
    endfunction

    task automatic compare_all();
        logic        h1, h2;
        logic [63:0] d1, d2;
        int          n;
        n = q.size();
        model_fwd(rs1, h1, d1);
        model_fwd(rs2, h2, d2);
        check("count",     64'(count),    64'(n));
        check("in_ready",  64'(in_ready), 64'(n < DEPTH));
        check("wen",       64'(wen),      64'((n != 0) && drain_en));
        check("rd",        64'(rd),       (n != 0) ? 64'(q[0].rd) : 64'd0);
        check("wd",        wd,            (n != 0) ? q[0].wd : 64'd0);
        check("fwd1_hit",  64'(fwd1_hit), 64'(h1));
        check("fwd1_data", fwd1_data,     d1);
        check("fwd2_hit",  64'(fwd2_hit), 64'(h2));
        check("fwd2_data", fwd2_data,     d2);
    endtask

    // Apply the edge to the model using the inputs present at that edge.
    task automatic update_model();
        int   n;
        logic rdy;
        logic ret;
        ent_t e;
        n   = q.size();
        rdy = (n < DEPTH);
        ret = (n != 0) && drain_en;
        if (rst) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (in_valid && rdy && (in_rd != 5'd0)) begin
                e.rd = in_rd;
                e.wd = in_wd;
                q.push_back(e);
            end
        end
    endtask

    // One clock: compare at the falling edge, step the model at the rising
    // edge, return just after it so the caller can drive the next inputs.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [63:0] d,
                         input logic dr);
        in_valid = v;
        in_rd    = r;
        in_wd    = d;
        drain_en = dr;
    endtask

    initial begin
        rst = 1'b1;
        rs1 = 5'd5;
        rs2 = 5'd5;
        drive(1'b0, 5'd0, 64'd0, 1'b1);
        // First edge brings the DUT out of its unknown power-up state.
        @(posedge clk);
        update_model();
        #1;
        cycle();

        // Reset state with the queue empty.
        rst = 1'b0;
        #1;
        check("rst_count",    64'(count),    64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wen",      64'(wen),      64'd0);
        check("rst_rd",       64'(rd),       64'd0);
        check("rst_wd",       wd,            64'd0);
        check("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
        check("rst_fwd2_dat", fwd2_data,     64'd0);

        // Single write: visible on the retire port the very next cycle.
        drive(1'b1, 5'd5, 64'h1234, 1'b1);
        cycle();
        drive(1'b0, 5'd0, 64'd0, 1'b1);
        #1;
        check("single_wen", 64'(wen), 64'd1);
        check("single_rd",  64'(rd),  64'd5);
        check("single_wd",  wd,       64'h1234);
        check("single_fwd", fwd1_data, 64'h1234);
        cycle();
        #1;
        check("single_cnt0", 64'(count), 64'd0);
        check("single_wen0", 64'(wen),   64'd0);

        // Fill with drain held off, offer one more, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 64'(100 + i), 1'b0);
            cycle();
        end
        #1;
        check("full_count", 64'(count),    64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_wen",   64'(wen),      64'd0);
        drive(1'b1, 5'd9, 64'h99, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 64'd0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_wen", 64'(wen), 64'd1);
            check("drain_rd",  64'(rd),  64'(i));
            cycle();
        end
        #1;
        check("drain_empty", 64'(count), 64'd0);

        // Youngest-wins bypass with duplicate destinations.
        drive(1'b1, 5'd7, 64'hA, 1'b0);
        cycle();
        drive(1'b1, 5'd7, 64'hB, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 64'd0, 1'b0);
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        check("yw_hit1",  64'(fwd1_hit), 64'd1);
        check("yw_data1", fwd1_data,     64'hB);
        check("yw_hit2",  64'(fwd2_hit), 64'd0);
        drain_en = 1'b1;
        cycle();
        #1;
        // Last entry is being written this cycle and must still forward.
        check("head_wen",  64'(wen),      64'd1);
        check("head_hit",  64'(fwd1_hit), 64'd1);
        check("head_data", fwd1_data,     64'hB);
        cycle();

        // x0 result is accepted and dropped.
        drive(1'b1, 5'd0, 64'hFF, 1'b1);
        cycle();
        drive(1'b0, 5'd0, 64'd0, 1'b1);
        #1;
        check("x0_count", 64'(count),    64'd0);
        check("x0_ready", 64'(in_ready), 64'd1);
        check("x0_wen",   64'(wen),      64'd0);
        cycle();

        // Full queue, then continuous enqueue while draining: pointers wrap.
        rs1 = 5'd12;
        rs2 = 5'd21;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 64'(200 + i), 1'b0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(20 + i), {$urandom, $urandom}, 1'b1);
            cycle();
        end
        #1;
        check("wrap_count", 64'(count), 64'd3);
        drive(1'b0, 5'd0, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle();

        // Mid-operation reset, colliding with an enqueue and a dequeue.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(3 + i), 64'(300 + i), 1'b0);
            cycle();
        end
        rst = 1'b1;
        drive(1'b1, 5'd4, 64'h44, 1'b1);
        cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 1'b1);
        #1;
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_wen",   64'(wen),   64'd0);
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic: small register range forces duplicates and x0.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_rd    = 5'($urandom_range(0, 7));
            in_wd    = {$urandom, $urandom};
            drain_en = $urandom_range(0, 2) != 0;
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
